// File: rtl/alu_status_pipe.sv
// Two-entry skid stage behind the ALU flag calculator. It retires entries into the NZCV status register and the sticky-V bit.
// Optional ALU_OVF_COUNT_EN adds a saturating 8-bit overflow retire counter (ovf_count).
package alu_ops;
  localparam logic [3:0] ADD_OP = 4'h0;
  localparam logic [3:0] SUB_OP = 4'h1;
  localparam logic [3:0] AND_OP = 4'h2;
  localparam logic [3:0] OR_OP  = 4'h3;
  localparam logic [3:0] XOR_OP = 4'h4;
endpackage

module alu_status_pipe #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_opcode,
  input  logic [W-1:0] in_result,
  input  logic         in_negative,
  input  logic         in_zero,
  input  logic         in_cout,
  input  logic         in_overflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags,
  output logic [3:0]   status,
  input  logic         status_clear,
  output logic         sticky_v
`ifdef ALU_OVF_COUNT_EN
  ,
  output logic [7:0]   ovf_count
`endif
);

  typedef struct packed {
    logic [W-1:0] op;
    logic [W-1:0] res;
    logic [3:0]   fl;
  } entry_t;

  // Slot 0 is always the head; slot 1 only holds data when two entries are buffered.
  entry_t     e0_q, e0_d, e1_q, e1_d, in_e;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] status_q, status_d;
  logic       sticky_q, sticky_d;
  logic       push, pop, flag_op;

  assign in_e       = '{op: in_opcode, res: in_result,
                        fl: {in_negative, in_zero, in_cout, in_overflow}};
  assign in_ready   = (cnt_q < 2'd2);
  assign out_valid  = (cnt_q != 2'd0);
  assign out_result = e0_q.res;
  assign out_flags  = e0_q.fl;
  assign status     = status_q;
  assign sticky_v   = sticky_q;

  assign push    = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign flag_op = (e0_q.op == W'(alu_ops::ADD_OP)) || (e0_q.op == W'(alu_ops::SUB_OP));

  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          e0_d  = in_e;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          e0_d = in_e;
        end else if (push) begin
          e1_d  = in_e;
          cnt_d = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          e0_d  = e1_q;
          cnt_d = 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    status_d = status_q;
    sticky_d = sticky_q;
    if (pop) begin
      status_d = flag_op ? e0_q.fl : {e0_q.fl[3:2], status_q[1:0]};
    end
    if (status_clear) begin
      status_d = 4'b0000;
      sticky_d = 1'b0;
    end
    // A retiring overflow beats a same-cycle clear of the sticky bit.
    if (pop && e0_q.fl[0]) begin
      sticky_d = 1'b1;
    end
  end

`ifdef ALU_OVF_COUNT_EN
  logic [7:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (pop && e0_q.fl[0] && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
    if (status_clear) begin
      ovf_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 8'd0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_count = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      e0_q     <= '0;
      e1_q     <= '0;
      status_q <= 4'b0000;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      e0_q     <= e0_d;
      e1_q     <= e1_d;
      status_q <= status_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_alu_status_pipe.sv
// Self-checking bench for alu_status_pipe: directed scenarios plus randomized traffic against a queue-based model.
// Define ALU_OVF_COUNT_EN on both files to exercise the overflow counter.
module tb_alu_status_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [3:0] in_result;
  logic       in_negative, in_zero, in_cout, in_overflow;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic [3:0] status;
  logic       status_clear;
  logic       sticky_v;
`ifdef ALU_OVF_COUNT_EN
  logic [7:0] ovf_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  alu_status_pipe #(.W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_result(in_result),
    .in_negative(in_negative), .in_zero(in_zero), .in_cout(in_cout), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .status(status), .status_clear(status_clear), .sticky_v(sticky_v)
`ifdef ALU_OVF_COUNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: an in-order queue of entries plus the retire-time status rules.
  typedef struct {
    logic [3:0] op;
    logic [3:0] res;
    logic [3:0] fl;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] m_status = 4'b0000;
  logic       m_sticky = 1'b0;
  int         m_ovf    = 0;

  task automatic model_edge();
    bit   do_push, do_pop;
    ent_t h, n;
    if (rst) begin
      mq.delete();
      m_status = 4'b0000;
      m_sticky = 1'b0;
      m_ovf    = 0;
      return;
    end
    do_push = in_valid && (mq.size() < 2);
    do_pop  = out_ready && (mq.size() > 0);
    if (status_clear) begin
      m_status = 4'b0000;
      m_sticky = 1'b0;
      m_ovf    = 0;
    end
    if (do_pop) begin
      h = mq.pop_front();
      if (!status_clear) begin
        if (h.op == alu_ops::ADD_OP || h.op == alu_ops::SUB_OP) m_status = h.fl;
        else m_status = {h.fl[3:2], m_status[1:0]};
      end
      if (h.fl[0]) begin
        m_sticky = 1'b1;
        if (!status_clear && m_ovf < 255) m_ovf = m_ovf + 1;
      end
    end
    if (do_push) begin
      n.op  = in_opcode;
      n.res = in_result;
      n.fl  = {in_negative, in_zero, in_cout, in_overflow};
      mq.push_back(n);
    end
  endtask

  // Advance one clock; inputs are only changed at the negedge where this returns.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] res, input logic [3:0] fl);
    in_opcode = op;
    in_result = res;
    {in_negative, in_zero, in_cout, in_overflow} = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; status_clear = 1'b0;
    drive(alu_ops::ADD_OP, 4'h5, 4'b1111);
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++;
    if (status !== 4'b0000) $display("FAIL reset_status: got %b expected 0000", status); else n_pass++;
    n_checks++;
    if (sticky_v !== 1'b0) $display("FAIL reset_sticky: got %b expected 0", sticky_v); else n_pass++;
    n_checks++;
    if ({out_result, out_flags} !== 8'h00) $display("FAIL reset_head: got %h expected 00", {out_result, out_flags}); else n_pass++;
  endtask

  task automatic test_single_add();
    out_ready = 1'b1; in_valid = 1'b1;
    drive(alu_ops::ADD_OP, 4'h0, 4'b0110);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL add_out_valid: got %b expected 1", out_valid); else n_pass++;
    n_checks++;
    if (out_result !== 4'h0) $display("FAIL add_out_result: got %h expected 0", out_result); else n_pass++;
    n_checks++;
    if (out_flags !== 4'b0110) $display("FAIL add_out_flags: got %b expected 0110", out_flags); else n_pass++;
    tick();
    n_checks++;
    if (status !== 4'b0110) $display("FAIL add_status: got %b expected 0110", status); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL add_drained: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nxt;
    bit will_push;
    int got[$];
    out_ready = 1'b0; in_valid = 1'b1;
    drive(alu_ops::AND_OP, 4'h1, 4'b0000);
    nxt = 2;
    for (int c = 0; c < 4; c++) begin
      will_push = in_valid && in_ready;
      tick();
      if (will_push) begin
        if (nxt <= 3) begin in_result = 4'(nxt); nxt++; end
        else in_valid = 1'b0;
      end
    end
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL b2b_full_in_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++;
    if (out_result !== 4'h1) $display("FAIL b2b_head_stable: got %h expected 1", out_result); else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      if (out_valid && out_ready) got.push_back(int'(out_result));
      will_push = in_valid && in_ready;
      tick();
      if (will_push) begin
        if (nxt <= 3) begin in_result = 4'(nxt); nxt++; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got.size() != 3) $display("FAIL b2b_count: got %0d entries expected 3", got.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= got.size()) $display("FAIL b2b_order[%0d]: got none expected %0d", i, i + 1);
      else if (got[i] != i + 1) $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, got[i], i + 1);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_nonflag();
    out_ready = 1'b1; in_valid = 1'b1;
    drive(alu_ops::SUB_OP, 4'h7, 4'b0011);
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (status !== 4'b0011) $display("FAIL sub_status: got %b expected 0011", status); else n_pass++;
    in_valid = 1'b1;
    drive(alu_ops::XOR_OP, 4'h9, 4'b1000);
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (status !== 4'b1011) $display("FAIL nonflag_status: got %b expected 1011", status); else n_pass++;
    n_checks++;
    if (sticky_v !== 1'b1) $display("FAIL nonflag_sticky: got %b expected 1", sticky_v); else n_pass++;
  endtask

  task automatic test_clear_pop();
    out_ready = 1'b1; in_valid = 1'b1;
    drive(alu_ops::ADD_OP, 4'h8, 4'b1001);
    tick();
    in_valid = 1'b0; status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    n_checks++;
    if (status !== 4'b0000) $display("FAIL clear_pop_status: got %b expected 0000", status); else n_pass++;
    n_checks++;
    if (sticky_v !== 1'b1) $display("FAIL clear_pop_sticky: got %b expected 1", sticky_v); else n_pass++;
`ifdef ALU_OVF_COUNT_EN
    n_checks++;
    if (ovf_count !== 8'd0) $display("FAIL clear_pop_ovf: got %0d expected 0", ovf_count); else n_pass++;
`endif
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    n_checks++;
    if (sticky_v !== 1'b0) $display("FAIL clear_sticky: got %b expected 0", sticky_v); else n_pass++;
  endtask

`ifdef ALU_OVF_COUNT_EN
  task automatic test_ovf_sat();
    out_ready = 1'b1; in_valid = 1'b1;
    drive(alu_ops::SUB_OP, 4'h3, 4'b0001);
    for (int i = 0; i < 260; i++) tick();
    in_valid = 1'b0;
    tick(); tick();
    n_checks++;
    if (ovf_count !== 8'd255) $display("FAIL ovf_saturate: got %0d expected 255", ovf_count); else n_pass++;
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    drive(alu_ops::ADD_OP, 4'hA, 4'b1111);
    tick(); tick();
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b01) $display("FAIL mid_full: got %b expected 01", {in_ready, out_valid}); else n_pass++;
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++;
    if (status !== 4'b0000) $display("FAIL mid_rst_status: got %b expected 0000", status); else n_pass++;
    n_checks++;
    if (sticky_v !== 1'b0) $display("FAIL mid_rst_sticky: got %b expected 0", sticky_v); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, status} !== 5'b0_0000) $display("FAIL mid_rst_no_retire: got %b expected 00000", {out_valid, status}); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int c = 0; c < 600; c++) begin
      n_checks++;
      if (in_ready !== (mq.size() < 2)) $display("FAIL rnd_in_ready @%0d: got %b expected %b", c, in_ready, mq.size() < 2); else n_pass++;
      n_checks++;
      if (out_valid !== (mq.size() != 0)) $display("FAIL rnd_out_valid @%0d: got %b expected %b", c, out_valid, mq.size() != 0); else n_pass++;
      if (mq.size() != 0) begin
        n_checks++;
        if ({out_result, out_flags} !== {mq[0].res, mq[0].fl})
          $display("FAIL rnd_head @%0d: got %h expected %h", c, {out_result, out_flags}, {mq[0].res, mq[0].fl});
        else n_pass++;
      end
      n_checks++;
      if ({status, sticky_v} !== {m_status, m_sticky})
        $display("FAIL rnd_status @%0d: got %b expected %b", c, {status, sticky_v}, {m_status, m_sticky});
      else n_pass++;
`ifdef ALU_OVF_COUNT_EN
      n_checks++;
      if (ovf_count !== 8'(m_ovf)) $display("FAIL rnd_ovf @%0d: got %0d expected %0d", c, ovf_count, m_ovf); else n_pass++;
`endif
      case ($urandom_range(0, 3))
        0:       op = alu_ops::ADD_OP;
        1:       op = alu_ops::SUB_OP;
        default: op = 4'($urandom_range(0, 15));
      endcase
      drive(op, 4'($urandom), 4'($urandom));
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      status_clear = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; status_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; status_clear = 1'b0;
    drive(4'h0, 4'h0, 4'h0);
    @(negedge clk);
    test_reset();
    test_single_add();
    test_back_to_back();
    test_nonflag();
    test_clear_pop();
`ifdef ALU_OVF_COUNT_EN
    test_ovf_sat();
`endif
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_status_pipe.md
Name: alu_status_pipe

Overview:
- Registered stage directly downstream of the ALU flag calculator.
- Captures each ALU result with its N/Z/C/V flags through a valid/ready handshake, buffering up to two entries in a skid buffer.
- On output handshake, updates an architectural NZCV status register and a sticky-overflow bit for use by the branch/condition logic.
- Decouples ALU timing from the consumer; no combinational path from out_ready to in_ready.

Parameters:
- W, 4, data width of result and opcode; matches the ALU/flag calculator W.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept an entry
- in_opcode  input  W  opcode (alu_ops encoding) of the entry
- in_result  input  W  ALU op_result
- in_negative  input  1  N flag from flag calculator
- in_zero  input  1  Z flag
- in_cout  input  1  C flag
- in_overflow  input  1  V flag
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head
- out_result  output  W  head result
- out_flags  output  4  head flags {N,Z,C,V}
- status  output  4  architectural NZCV {N,Z,C,V}
- status_clear  input  1  synchronous clear of status and sticky_v
- sticky_v  output  1  set by any retired entry with V=1

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - count=0, out_valid=0, in_ready=1, out_result=0, out_flags=0, status=0, sticky_v=0.
  - Handshakes in a cycle with rst=1 are discarded.
- Storage: 2-entry FIFO (skid); entry = {opcode, result, N, Z, C, V}; strict FIFO order.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count < 2), taken from registered state only.
- out_valid = (count != 0); out_result/out_flags show the head; head is stable while out_valid && !out_ready.
- Latency: entry pushed in cycle t appears at output in t+1 when the FIFO was empty.
- Count transitions:
  - count=0: push gives count=1.
  - count=1: push and pop together keep count=1 (new entry becomes head next cycle); push only gives 2; pop only gives 0.
  - count=2: in_ready=0, so no push; pop gives 1.
  - Full throughput: 1 entry/cycle sustained when out_ready=1.
- Status update on pop, registered, visible next cycle:
  - Head opcode is alu_ops::ADD_OP or alu_ops::SUB_OP: N, Z, C, V all take the head flags.
  - Any other opcode: N and Z update; C and V hold their previous values.
- sticky_v: set on pop with head V=1.
- status_clear:
  - Clears status to 0, and clear wins over a same-cycle pop update.
  - Clears sticky_v, but a same-cycle pop with V=1 wins and sticky_v ends 1.
  - Does not affect FIFO contents.
- Reset mid-operation: FIFO contents dropped; both buffered entries lost without retiring (no status update).
- Flags are passed through unmodified; no recomputation from result.

Optional Feature:
- Macro ALU_OVF_COUNT_EN.
- Defined:
  - Adds output port ovf_count [7:0], reset 0.
  - Increments on each pop with head V=1 and saturates at 255.
  - status_clear forces it to 0; clear wins over a same-cycle increment.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then idle: out_valid=0, in_ready=1, status=4'b0000, sticky_v=0; in_valid=1 while rst=1 does not make out_valid=1 after reset.
- Single ADD_OP entry {result=4'h0, N0 Z1 C1 V0}, out_ready=1: out_valid=1 one cycle later with out_result=0, out_flags=4'b0110; next cycle status=4'b0110.
- out_ready=0, push 3 back-to-back entries (results 1, 2, 3): in_ready drops after 2 pushes, third held by upstream; release out_ready: outputs 1, 2, 3 in order, no loss or duplication.
- Non-flag opcode after SUB_OP with C=1 V=1: pop entry {N1 Z0 C0 V0}; status becomes 4'b1011 (C and V retained).
- Pop with V=1 and status_clear=1 same cycle: status=0, sticky_v=1; with ALU_OVF_COUNT_EN, ovf_count=0.
- With ALU_OVF_COUNT_EN: 260 retired V=1 entries give ovf_count=255; rst mid-stream with count=2 gives out_valid=0 and status unchanged by dropped entries.
